seq_multiplier: RTL
===================

Name: seq_multiplier

Overview:
Unsigned sequential shift-and-add multiplier. It is the inverse-operation companion to the restoring divider datapath.
It accepts two nBit operands on a start pulse and produces a 2*nBit product after nBit iteration cycles, one partial-product bit per cycle.
It sits beside the divider in the arithmetic unit and shares its start/busy/done handshake.

Parameters:
nBit, 16, operand width in bits; product width is 2*nBit; nBit >= 2.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when the block is idle (state IDLE or DONE).
A  input  nBit  multiplicand, unsigned; captured on an accepted start.
B  input  nBit  multiplier, unsigned; captured on an accepted start.
busy  output  1  high while iterating (state RUN).
done  output  1  one-cycle pulse; P is valid from this cycle.
P  output  2*nBit  product register; holds the last result until the next completion.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, P=0, internal accumulator, multiplier register and counter all 0.
- States and transitions:
  - IDLE: if start, go to RUN.
  - RUN: iterate; when the iteration count reaches nBit, go to DONE.
  - DONE: done=1 for this cycle only. If start is high, go to RUN; otherwise go to IDLE.
- Accepted start (IDLE or DONE):
  - mcand <= A, mreg <= B, acc <= 0, cnt <= 0.
  - busy goes to 1 from the next cycle.
- RUN iteration, one per cycle:
  - sum[nBit:0] = acc + (mreg[0] ? mcand : 0). The carry is kept, so no overflow is lost.
  - {acc, mreg} <= {sum, mreg[nBit-1:1]}, i.e. {carry, acc, mreg} shifted right by 1.
  - cnt <= cnt + 1. cnt is clog2(nBit)+1 bits wide and must not wrap before reaching nBit.
- Completion: on the edge that performs iteration nBit, P <= {acc_next, mreg_next}, state <= DONE, busy <= 0, done <= 1.
- Latency: done is high exactly nBit cycles after the edge that accepted start (16 cycles at the default). The throughput interval is nBit+1 cycles for back-to-back starts.
- start while in RUN is ignored. No queuing; operands already captured are unaffected.
- A and B may change freely after the accepting edge.
- P is not disturbed during RUN; it holds the previous result until the completion edge.
- rst asserted in any state, including mid-RUN, aborts the operation. The next cycle shows the reset values (P=0). No done pulse is emitted for the aborted operation.
- rst and start high on the same edge: rst wins and start is dropped.
- All arithmetic is unsigned. Zero operands need no special casing: the full nBit iterations always run, with no early termination.

Decomposition:
- Shared include file holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default width constant, shared with the divider.
- One sub-module: nbit_adder (parameter nBit). It is a ripple adder built from the existing half_adder/full_adder cells, with inputs X[nBit-1:0], Y[nBit-1:0] and outputs S[nBit-1:0], cout.
- It forms sum = {cout, S} each iteration. The FSM, counter and shift registers stay in seq_multiplier.

Test Plan:
1. Basic product and latency: A=3, B=5, one-cycle start from IDLE -> busy=1 for 16 cycles, done pulses exactly once 16 cycles after start, P=32'h0000000F and held after done falls.
2. Maximum operands: A=16'hFFFF, B=16'hFFFF -> P=32'hFFFE0001, which checks that the carry is kept on every iteration.
3. Identity and zero: A=0, B=16'h1234 -> P=0 with full 16-cycle latency. Then A=16'h1234, B=1 -> P=32'h00001234.
4. Ignored start: A=10, B=20 accepted; at RUN cycle 4 assert start with A=7, B=7 -> single done, P=32'h000000C8, block returns to IDLE.
5. Reset mid-operation: A=16'hABCD, B=2; assert rst at RUN cycle 5 -> next cycle busy=0, done=0, P=0, and no done pulse follows. A fresh start with A=6, B=7 -> P=42.
6. Back-to-back: 7x9, with start held high in the DONE cycle carrying A=16'h8000, B=2 -> first done shows P=63, second done 17 cycles later shows P=32'h00010000, and P holds 63 throughout the second RUN.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential multiplier (and its divider sibling).
//   DEFAULT_NBIT : default operand width for the arithmetic unit
//   state_t      : handshake FSM encoding (IDLE / RUN / DONE)
package seq_multiplier_pkg;

    localparam int DEFAULT_NBIT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   x, y : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
//   x, y : addend bits
//   s    : sum bit
//   c    : carry out
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/nbit_adder.sv
// Unsigned ripple-carry adder built from half/full adder cells.
//   X, Y : nBit addends
//   S    : nBit sum
//   cout : carry out of the top bit
module nbit_adder #(
    parameter int nBit = 16
) (
    input  logic [nBit-1:0] X,
    input  logic [nBit-1:0] Y,
    output logic [nBit-1:0] S,
    output logic            cout
);

    logic [nBit-1:0] carry;

    // Bit 0 has no carry in, so a half adder is enough there.
    half_adder u_ha0 (
        .x (X[0]),
        .y (Y[0]),
        .s (S[0]),
        .c (carry[0])
    );

    for (genvar i = 1; i < nBit; i++) begin : g_fa
        full_adder u_fa (
            .x  (X[i]),
            .y  (Y[i]),
            .ci (carry[i-1]),
            .s  (S[i]),
            .co (carry[i])
        );
    end

    assign cout = carry[nBit-1];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add sequential multiplier, one multiplier bit per cycle.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, honoured only in IDLE or DONE
//   A, B  : multiplicand / multiplier, captured on an accepted start
//   busy  : high while iterating
//   done  : one-cycle pulse, P valid from this cycle
//   P     : product register, holds the last result
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start
// RUN     | one add/shift per cycle, nBit cycles total
// DONE    | result just written to P; start here re-launches at once
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int nBit = DEFAULT_NBIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [nBit-1:0]   A,
    input  logic [nBit-1:0]   B,
    output logic              busy,
    output logic              done,
    output logic [2*nBit-1:0] P
);

    // One extra bit so the counter can represent nBit itself without wrapping.
    localparam int CNT_W = $clog2(nBit) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(nBit - 1);

    state_t            state;
    logic [nBit-1:0]   mcand;
    logic [nBit-1:0]   mreg;
    logic [nBit-1:0]   acc;
    logic [CNT_W-1:0]  cnt;

    logic [nBit-1:0]   addend;
    logic [nBit-1:0]   sum_low;
    logic              sum_carry;
    logic [nBit:0]     sum;
    logic [nBit-1:0]   acc_next;
    logic [nBit-1:0]   mreg_next;

    assign addend = mreg[0] ? mcand : '0;

    nbit_adder #(
        .nBit (nBit)
    ) u_adder (
        .X    (acc),
        .Y    (addend),
        .S    (sum_low),
        .cout (sum_carry)
    );

    // {carry, acc, mreg} shifted right by one: the carry lands in acc's MSB
    // and the sum's LSB becomes the next product bit at the top of mreg.
    assign sum       = {sum_carry, sum_low};
    assign acc_next  = sum[nBit:1];
    assign mreg_next = {sum[0], mreg[nBit-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            P     <= '0;
            mcand <= '0;
            mreg  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_RUN: begin
                    acc  <= acc_next;
                    mreg <= mreg_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        P     <= {acc_next, mreg_next};
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        mcand <= A;
                        mreg  <= B;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
